// File: rtl/debug_controller.sv
// debug_controller: halt/step/resume run-control and debug register
// reads for the 5-stage pipeline, driven by a host command channel.
module debug_controller #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DRAIN_TIMEOUT  = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [REG_ADDR_WIDTH-1:0] cmd_reg,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic                      rsp_err,
  output logic                      halted,
  output logic                      pipe_fetch_en,
  input  logic                      pipe_fetch_fire,
  input  logic                      pipe_retire_valid,
  input  logic                      pipe_empty,
  output logic [REG_ADDR_WIDTH-1:0] rf_dbg_addr,
  input  logic [DATA_WIDTH-1:0]     rf_dbg_data
);

  localparam int TW =
    (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(DRAIN_TIMEOUT - 1);

  localparam logic [1:0] OP_HALT   = 2'b00;
  localparam logic [1:0] OP_RESUME = 2'b01;
  localparam logic [1:0] OP_STEP   = 2'b10;
  localparam logic [1:0] OP_READ   = 2'b11;

  typedef enum logic [2:0] {
    S_RUN,
    S_DRAIN,
    S_HALTED,
    S_STEP_ISSUE,
    S_STEP_WAIT,
    S_READ
  } state_t;

  state_t                    state_q, state_d;
  logic [TW-1:0]             tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0]     ret_q, ret_d, ret_inc;
  logic                      rsp_valid_d, rsp_err_d;
  logic [DATA_WIDTH-1:0]     rsp_data_d;
  logic [REG_ADDR_WIDTH-1:0] addr_d;
  logic                      accept;
  logic                      tmo_hit;

  assign pipe_fetch_en = (state_q == S_RUN) ||
                         (state_q == S_STEP_ISSUE);
  assign halted    = (state_q == S_HALTED);
  assign cmd_ready = ((state_q == S_RUN) ||
                      (state_q == S_HALTED)) && !rsp_valid;
  assign accept    = cmd_valid && cmd_ready;
  assign tmo_hit   = (tmo_q == T_LAST);

  // retire count saturates instead of wrapping
  assign ret_inc = (pipe_retire_valid && (ret_q != '1)) ?
                   ret_q + DATA_WIDTH'(1) : ret_q;

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    ret_d       = ret_q;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;
    rsp_err_d   = rsp_err;
    addr_d      = rf_dbg_addr;
    if (rsp_valid && rsp_ready) rsp_valid_d = 1'b0;
    unique case (state_q)
      S_RUN: if (accept) begin
        rsp_data_d = '0;
        unique case (1'b1)
          (cmd_op == OP_HALT): begin
            state_d = S_DRAIN;
            tmo_d   = '0;
          end
          (cmd_op == OP_RESUME): begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
          end
          default: begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        endcase
      end
      S_DRAIN: begin
        if (pipe_empty || tmo_hit) begin
          state_d     = S_HALTED;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = !pipe_empty;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_HALTED: if (accept) begin
        rsp_data_d = '0;
        unique case (1'b1)
          (cmd_op == OP_HALT): begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
          end
          (cmd_op == OP_RESUME): begin
            state_d     = S_RUN;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
          end
          (cmd_op == OP_STEP): begin
            state_d = S_STEP_ISSUE;
            ret_d   = '0;
          end
          default: begin
            state_d = S_READ;
            addr_d  = cmd_reg;
          end
        endcase
      end
      S_STEP_ISSUE: if (pipe_fetch_fire) begin
        state_d = S_STEP_WAIT;
        tmo_d   = '0;
      end
      S_STEP_WAIT: begin
        ret_d = ret_inc;
        if (pipe_empty || tmo_hit) begin
          state_d     = S_HALTED;
          rsp_valid_d = 1'b1;
          rsp_data_d  = ret_inc;
          rsp_err_d   = !pipe_empty;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_READ: begin
        state_d     = S_HALTED;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        // x0 is hardwired zero regardless of the port value
        rsp_data_d  = (rf_dbg_addr == '0) ? '0 : rf_dbg_data;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      tmo_q       <= '0;
      ret_q       <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      rf_dbg_addr <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      ret_q       <= ret_d;
      rsp_valid   <= rsp_valid_d;
      rsp_data    <= rsp_data_d;
      rsp_err     <= rsp_err_d;
      rf_dbg_addr <= addr_d;
    end
  end

endmodule

// File: tb/tb_debug_controller.sv
// tb_debug_controller: table vectors, timing sequences and random
// commands checked against a transaction-level model.
`timescale 1ns/1ps
module tb_debug_controller;

  localparam int TMO = 64;
  localparam logic [1:0] OP_HALT   = 2'b00;
  localparam logic [1:0] OP_RESUME = 2'b01;
  localparam logic [1:0] OP_STEP   = 2'b10;
  localparam logic [1:0] OP_READ   = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [4:0]  cmd_reg = 5'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        halted;
  logic        pipe_fetch_en;
  logic        pipe_fetch_fire = 1'b0;
  logic        pipe_retire_valid = 1'b0;
  logic        pipe_empty = 1'b0;
  logic [4:0]  rf_dbg_addr;
  logic [31:0] rf_dbg_data;
  logic [31:0] mem [32];

  int n_cmp = 0;
  int n_bad = 0;
  bit m_halted = 1'b0;

  always #5 clk = ~clk;
  assign rf_dbg_data = mem[rf_dbg_addr];

  debug_controller #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .DRAIN_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_reg(cmd_reg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .halted(halted), .pipe_fetch_en(pipe_fetch_en),
    .pipe_fetch_fire(pipe_fetch_fire),
    .pipe_retire_valid(pipe_retire_valid),
    .pipe_empty(pipe_empty),
    .rf_dbg_addr(rf_dbg_addr), .rf_dbg_data(rf_dbg_data)
  );

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  r;
    int          k;
    int          f;
    int          w;
    logic [31:0] pat;
    logic        e;
    logic [31:0] d;
    bit          h;
  } vec_t;

  vec_t tbl[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic cmd1(input logic [1:0] op, input logic [4:0] r);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_reg   = r;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  // one full command: wait ready, issue, play pipeline, handshake
  task automatic issue(
    input logic [1:0] op, input logic [4:0] r,
    input int k, input int f, input int w,
    input logic [31:0] pat, input int hold,
    output bit ok, output logic e, output logic [31:0] d,
    output bit stable, output bit clr);
    int n;
    n = 0;
    ok = 1'b0; e = 1'b0; d = '0; stable = 1'b0; clr = 1'b0;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    cmd1(op, r);
    for (int c = 0; c < 200 && !rsp_valid; c++) begin
      if (op == OP_HALT && !m_halted) pipe_empty = (c >= k);
      if (op == OP_STEP && m_halted) begin
        pipe_fetch_fire   = (c == f);
        pipe_retire_valid = (c < 32) ? pat[c] : 1'b0;
        pipe_empty        = (c == f + 1 + w);
      end
      tick();
    end
    pipe_fetch_fire   = 1'b0;
    pipe_retire_valid = 1'b0;
    ok = rsp_valid;
    e  = rsp_err;
    d  = rsp_data;
    repeat (hold) tick();
    stable = ok && rsp_valid && (rsp_err === e) && (rsp_data === d);
    ack();
    clr = !rsp_valid && cmd_ready;
  endtask

  task automatic check_cmd(
    input string tag, input logic [1:0] op, input logic [4:0] r,
    input int k, input int f, input int w,
    input logic [31:0] pat, input int hold,
    input logic xe, input logic [31:0] xd, input bit xh);
    bit ok, stable, clr;
    logic e;
    logic [31:0] d;
    issue(op, r, k, f, w, pat, hold, ok, e, d, stable, clr);
    chk({tag, ".rsp"}, 32'(ok), 32'd1);
    chk({tag, ".err"}, 32'(e), 32'(xe));
    chk({tag, ".data"}, d, xd);
    chk({tag, ".hold"}, 32'(stable), 32'd1);
    chk({tag, ".clear"}, 32'(clr), 32'd1);
    chk({tag, ".halted"}, 32'(halted), 32'(xh));
    m_halted = xh;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [1:0]  op;
    logic [4:0]  r;
    int          k, f, w, hold;
    logic [31:0] pat, xd;
    logic        xe;
    bit          xh;

    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[5] = 32'hDEADBEEF;
    mem[0] = 32'h00001234;

    tbl[0]  = '{OP_READ,   5'd3, 0, 0, 0, 32'h0, 1'b1, 32'h0, 1'b0};
    tbl[1]  = '{OP_STEP,   5'd0, 0, 0, 0, 32'h0, 1'b1, 32'h0, 1'b0};
    tbl[2]  = '{OP_RESUME, 5'd0, 0, 0, 0, 32'h0, 1'b0, 32'h0, 1'b0};
    tbl[3]  = '{OP_HALT,   5'd0, 0, 0, 0, 32'h0, 1'b0, 32'h0, 1'b1};
    tbl[4]  = '{OP_HALT,   5'd0, 0, 0, 0, 32'h0, 1'b0, 32'h0, 1'b1};
    tbl[5]  = '{OP_READ,   5'd5, 0, 0, 0, 32'h0, 1'b0,
                32'hDEADBEEF, 1'b1};
    tbl[6]  = '{OP_READ,   5'd0, 0, 0, 0, 32'h0, 1'b0, 32'h0, 1'b1};
    tbl[7]  = '{OP_STEP,   5'd0, 0, 0, 2, 32'hF, 1'b0, 32'd3, 1'b1};
    tbl[8]  = '{OP_STEP,   5'd0, 0, 2, 0, 32'hFFFFFFFF, 1'b0,
                32'd1, 1'b1};
    tbl[9]  = '{OP_RESUME, 5'd0, 0, 0, 0, 32'h0, 1'b0, 32'h0, 1'b0};
    tbl[10] = '{OP_HALT,   5'd0, 63, 0, 0, 32'h0, 1'b0, 32'h0, 1'b1};
    tbl[11] = '{OP_RESUME, 5'd0, 0, 0, 0, 32'h0, 1'b0, 32'h0, 1'b0};
    tbl[12] = '{OP_HALT,   5'd0, 64, 0, 0, 32'h0, 1'b1, 32'h0, 1'b1};
    tbl[13] = '{OP_RESUME, 5'd0, 0, 0, 0, 32'h0, 1'b0, 32'h0, 1'b0};

    // reset
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst.fetch_en", 32'(pipe_fetch_en), 32'd1);
    chk("rst.halted", 32'(halted), 32'd0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst.addr", 32'(rf_dbg_addr), 32'd0);

    for (int i = 0; i < 14; i++)
      check_cmd($sformatf("tbl%0d", i), tbl[i].op, tbl[i].r,
                tbl[i].k, tbl[i].f, tbl[i].w, tbl[i].pat,
                i % 3, tbl[i].e, tbl[i].d, tbl[i].h);

    // halt with pipe_empty arriving at T+3, held response
    pipe_empty = 1'b0;
    cmd1(OP_HALT, 5'd0);
    chk("halt.fetch_en_t1", 32'(pipe_fetch_en), 32'd0);
    tick();
    tick();
    pipe_empty = 1'b1;
    chk("halt.no_rsp_t3", 32'(rsp_valid), 32'd0);
    tick();
    chk("halt.rsp_t4", 32'(rsp_valid), 32'd1);
    chk("halt.err_t4", 32'(rsp_err), 32'd0);
    chk("halt.halted_t4", 32'(halted), 32'd1);
    repeat (3) tick();
    chk("halt.held", 32'({rsp_valid, rsp_err}), 32'b10);
    ack();
    chk("halt.cleared", 32'({rsp_valid, cmd_ready}), 32'b01);

    // read timing
    cmd1(OP_READ, 5'd5);
    chk("read.addr_t1", 32'(rf_dbg_addr), 32'd5);
    chk("read.no_rsp_t1", 32'(rsp_valid), 32'd0);
    tick();
    chk("read.rsp_t2", 32'(rsp_valid), 32'd1);
    chk("read.data_t2", rsp_data, 32'hDEADBEEF);
    ack();

    // step: fire held off two cycles
    pipe_empty = 1'b0;
    cmd1(OP_STEP, 5'd0);
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      pipe_fetch_fire = (c == 2);
      if (pipe_fetch_en) cnt++;
      tick();
    end
    pipe_fetch_fire = 1'b0;
    chk("step.fetch_cycles", 32'(cnt), 32'd3);
    chk("step.fetch_off", 32'(pipe_fetch_en), 32'd0);
    pipe_retire_valid = 1'b1;
    tick();
    pipe_retire_valid = 1'b0;
    pipe_empty = 1'b1;
    tick();
    chk("step.rsp", 32'({rsp_valid, rsp_err}), 32'b10);
    chk("step.data", rsp_data, 32'd1);
    chk("step.halted", 32'(halted), 32'd1);
    ack();

    // reset while a response is pending, then while draining
    cmd1(OP_RESUME, 5'd0);
    cmd1(OP_READ, 5'd1);
    chk("rst2.pending", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst2.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst2.fetch_en", 32'(pipe_fetch_en), 32'd1);
    pipe_empty = 1'b0;
    cmd1(OP_HALT, 5'd0);
    chk("rst3.draining", 32'(pipe_fetch_en), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst3.fetch_en", 32'(pipe_fetch_en), 32'd1);
    chk("rst3.state", 32'({halted, cmd_ready}), 32'b01);
    m_halted = 1'b0;

    // random commands against the transaction model
    for (int i = 0; i < 150; i++) begin
      op   = 2'($urandom_range(0, 3));
      r    = 5'($urandom);
      k    = ($urandom_range(0, 3) == 0) ?
             $urandom_range(60, 70) : $urandom_range(0, 5);
      f    = $urandom_range(0, 4);
      w    = $urandom_range(0, 10);
      pat  = $urandom;
      hold = $urandom_range(0, 3);
      xe   = 1'b0;
      xd   = '0;
      xh   = m_halted;
      case (op)
        OP_HALT: begin
          xe = !m_halted && (k >= TMO);
          xh = 1'b1;
        end
        OP_RESUME: xh = 1'b0;
        OP_STEP: begin
          xe = !m_halted;
          if (m_halted)
            for (int b = f + 1; b <= f + 1 + w; b++)
              xd = xd + 32'(pat[b]);
        end
        default: begin
          xe = !m_halted;
          if (m_halted && r != 5'd0) xd = mem[r];
        end
      endcase
      check_cmd($sformatf("rnd%0d", i), op, r, k, f, w, pat,
                hold, xe, xd, xh);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
